// File: rtl/adc_sample_monitor.sv
// Moving-average monitor for reassembled ADC samples: averages the last 2^AVG_LOG2
// codes, classifies each average against fixed limits and latches a sticky range fault.
module adc_sample_monitor #(
    parameter int          AVG_LOG2    = 3,
    parameter logic [11:0] HI_TH       = 12'd3000,
    parameter logic [11:0] LO_TH       = 12'd1000,
    parameter int          FAULT_COUNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sample,
    input  logic        sample_valid,
    input  logic        clear_fault,
    output logic [11:0] avg,
    output logic        avg_valid,
    output logic        in_range,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int SUM_W = 12 + AVG_LOG2;
    localparam int WIN_D = 1 << AVG_LOG2;

    localparam logic [AVG_LOG2:0] FILL_FULL = {1'b1, {AVG_LOG2{1'b0}}};
    localparam logic [AVG_LOG2:0] FILL_ONE  = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2:0] FILL_LAST = FILL_FULL - FILL_ONE;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_OVER  = 2'b01;
    localparam logic [1:0] DIR_UNDER = 2'b10;

    localparam logic [3:0] CNT_MAX  = 4'(FAULT_COUNT);
    localparam logic [3:0] CNT_ZERO = 4'd0;
    localparam logic [3:0] CNT_ONE  = 4'd1;

    // Stage 1: window storage and running sum
    logic [11:0]         win_r [WIN_D];
    logic [AVG_LOG2-1:0] ptr_r;
    logic [AVG_LOG2:0]   fill_r;
    logic [SUM_W-1:0]    sum_r;
    logic                upd_r;

    logic [11:0]         oldest_s;
    logic [SUM_W-1:0]    sum_nxt_s;

    // Stage 2: average and classification
    logic [11:0] avg_r;
    logic        avg_valid_r;
    logic        in_range_r;
    logic        over_r;
    logic        under_r;

    logic [11:0] avg_s;
    logic        over_s;
    logic        under_s;

    // Stage 3: trip tracking
    logic [3:0] cnt_r;
    logic [1:0] dir_r;
    logic       fault_r;
    logic [1:0] code_r;

    logic [1:0] cls_dir_s;
    logic [3:0] cnt_nxt_s;
    logic [1:0] dir_nxt_s;
    logic       fault_nxt_s;
    logic [1:0] code_nxt_s;

    // Until the window has been filled once, the slot being overwritten holds stale data
    always_comb begin
        oldest_s = 12'd0;
        if (fill_r == FILL_FULL) begin
            oldest_s = win_r[ptr_r];
        end else begin
            oldest_s = 12'd0;
        end
        sum_nxt_s = sum_r + SUM_W'(sample) - SUM_W'(oldest_s);
    end

    // Window RAM: no reset, fill gating masks its contents
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            win_r[ptr_r] <= sample;
        end
    end

    // Running sum, write pointer, fill counter and first-stage update flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= '0;
            ptr_r  <= '0;
            fill_r <= '0;
            upd_r  <= 1'b0;
        end else begin
            upd_r <= sample_valid && (fill_r >= FILL_LAST);
            if (sample_valid) begin
                sum_r <= sum_nxt_s;
                ptr_r <= ptr_r + AVG_LOG2'(1);
                if (fill_r != FILL_FULL) begin
                    fill_r <= fill_r + FILL_ONE;
                end
            end
        end
    end

    // Truncating divide by the window depth; the quotient always fits 12 bits
    always_comb begin
        avg_s   = 12'(sum_r >> AVG_LOG2);
        over_s  = (avg_s > HI_TH);
        under_s = (avg_s < LO_TH);
    end

    // Average register and range classification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_r       <= 12'd0;
            avg_valid_r <= 1'b0;
            in_range_r  <= 1'b1;
            over_r      <= 1'b0;
            under_r     <= 1'b0;
        end else begin
            avg_valid_r <= upd_r;
            if (upd_r) begin
                avg_r      <= avg_s;
                in_range_r <= !(over_s || under_s);
                over_r     <= over_s;
                under_r    <= under_s;
            end
        end
    end

    // Direction of the average presented this cycle
    always_comb begin
        cls_dir_s = DIR_NONE;
        if (over_r) begin
            cls_dir_s = DIR_OVER;
        end else if (under_r) begin
            cls_dir_s = DIR_UNDER;
        end else begin
            cls_dir_s = DIR_NONE;
        end
    end

    // Trip counter and fault latch; clear_fault overrides any classification this cycle
    always_comb begin
        cnt_nxt_s   = cnt_r;
        dir_nxt_s   = dir_r;
        fault_nxt_s = fault_r;
        code_nxt_s  = code_r;
        if (clear_fault) begin
            cnt_nxt_s   = CNT_ZERO;
            dir_nxt_s   = DIR_NONE;
            fault_nxt_s = 1'b0;
            code_nxt_s  = DIR_NONE;
        end else if (avg_valid_r) begin
            if (cls_dir_s == DIR_NONE) begin
                cnt_nxt_s = CNT_ZERO;
                dir_nxt_s = DIR_NONE;
            end else if (cls_dir_s == dir_r) begin
                if (cnt_r != CNT_MAX) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                dir_nxt_s = dir_r;
            end else begin
                cnt_nxt_s = CNT_ONE;
                dir_nxt_s = cls_dir_s;
            end

            if ((cnt_nxt_s == CNT_MAX) && !fault_r && (cls_dir_s != DIR_NONE)) begin
                fault_nxt_s = 1'b1;
                code_nxt_s  = cls_dir_s;
            end else begin
                fault_nxt_s = fault_r;
                code_nxt_s  = code_r;
            end
        end else begin
            cnt_nxt_s   = cnt_r;
            dir_nxt_s   = dir_r;
            fault_nxt_s = fault_r;
            code_nxt_s  = code_r;
        end
    end

    // Trip state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= CNT_ZERO;
            dir_r   <= DIR_NONE;
            fault_r <= 1'b0;
            code_r  <= DIR_NONE;
        end else begin
            cnt_r   <= cnt_nxt_s;
            dir_r   <= dir_nxt_s;
            fault_r <= fault_nxt_s;
            code_r  <= code_nxt_s;
        end
    end

    assign avg        = avg_r;
    assign avg_valid  = avg_valid_r;
    assign in_range   = in_range_r;
    assign fault      = fault_r;
    assign fault_code = code_r;

endmodule

// File: tb/tb_adc_sample_monitor.sv
// Directed bench for adc_sample_monitor (W=8, limits 1000..3000, trip after 4).
module tb_adc_sample_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] sample = 12'd0;
    logic        sample_valid = 1'b0;
    logic        clear_fault = 1'b0;
    logic [11:0] avg;
    logic        avg_valid;
    logic        in_range;
    logic        fault;
    logic [1:0]  fault_code;

    int n_cmp = 0;
    int n_mis = 0;

    int cyc = 0;
    int last_drv_cyc = 0;
    int ev_cyc[$];
    int ev_avg[$];
    int ev_rng[$];
    int n_rise = 0;
    int rise_cyc = -1;
    logic fault_q = 1'b0;

    adc_sample_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .clear_fault  (clear_fault),
        .avg          (avg),
        .avg_valid    (avg_valid),
        .in_range     (in_range),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #10 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Record every average pulse and every rising edge of fault
    always @(negedge clk) begin
        if (avg_valid) begin
            ev_cyc.push_back(cyc);
            ev_avg.push_back(int'(avg));
            ev_rng.push_back(int'(in_range));
        end
        if (fault && !fault_q) begin
            n_rise   <= n_rise + 1;
            rise_cyc <= cyc;
        end
        fault_q <= fault;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int idx, input int exp_avg, input int exp_rng);
        int present;
        present = (idx < ev_avg.size()) ? 1 : 0;
        check_eq({tag, "_present"}, present, 1);
        if (present == 1) begin
            check_eq({tag, "_avg"}, ev_avg[idx], exp_avg);
            check_eq({tag, "_rng"}, ev_rng[idx], exp_rng);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_avg"},   int'(avg), 0);
        check_eq({tag, "_avgv"},  int'(avg_valid), 0);
        check_eq({tag, "_rng"},   int'(in_range), 1);
        check_eq({tag, "_fault"}, int'(fault), 0);
        check_eq({tag, "_code"},  int'(fault_code), 0);
    endtask

    task automatic tick(input logic v, input logic [11:0] s, input logic c);
        @(negedge clk);
        last_drv_cyc = cyc;
        sample_valid = v;
        sample       = s;
        clear_fault  = c;
    endtask

    task automatic feed(input int n, input logic [11:0] s);
        for (int i = 0; i < n; i++) tick(1'b1, s, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 12'd0, 1'b0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        clear_fault  = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        last_drv_cyc = cyc;
    endtask

    initial begin
        int base;
        int first;
        int r0;
        int exp2 [8] = '{2303, 2559, 2815, 3071, 3327, 3583, 3839, 4095};
        int rng2 [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        int exp4 [11] = '{4095, 3583, 3071, 2559, 2047, 1535, 1023, 511, 0, 511, 1023};
        int rng4 [11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        rst_n = 1'b1;
        last_drv_cyc = cyc;

        // Test 1: fill with 2048, single average two cycles after the 8th strobe
        base = ev_avg.size();
        feed(8, 12'd2048);
        first = last_drv_cyc;
        idle(4);
        check_eq("t1_count", ev_avg.size() - base, 1);
        check_ev("t1_ev", base, 2048, 1);
        if (ev_cyc.size() > base) check_eq("t1_lat", ev_cyc[base], first + 2);
        check_eq("t1_fault", int'(fault), 0);

        // Test 2: ramp toward 4095, trip on the 4th over-range average
        base  = ev_avg.size();
        r0    = n_rise;
        first = last_drv_cyc + 1;
        feed(8, 12'd4095);
        idle(4);
        check_eq("t2_count", ev_avg.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            check_ev($sformatf("t2_ev%0d", i), base + i, exp2[i], rng2[i]);
            if (ev_cyc.size() > base + i) check_eq($sformatf("t2_cyc%0d", i), ev_cyc[base + i], first + i + 2);
        end
        check_eq("t2_rises", n_rise - r0, 1);
        check_eq("t2_rise_cyc", rise_cyc, first + 9);
        check_eq("t2_fault", int'(fault), 1);
        check_eq("t2_code", int'(fault_code), 1);
        tick(1'b0, 12'd0, 1'b1);
        tick(1'b0, 12'd0, 1'b0);
        check_eq("t2_clr_fault", int'(fault), 0);
        check_eq("t2_clr_code", int'(fault_code), 0);

        // Test 3: averages sitting exactly on the limits are in range
        pulse_reset("t3_rst");
        base = ev_avg.size();
        r0   = n_rise;
        feed(10, 12'd3000);
        feed(10, 12'd1000);
        idle(4);
        check_eq("t3_count", ev_avg.size() - base, 13);
        for (int i = 0; i < 13; i++) begin
            int k;
            int e;
            k = i - 2;
            if (k < 1) e = 3000;
            else if (k > 8) e = 1000;
            else e = 3000 - 250 * k;
            check_ev($sformatf("t3_ev%0d", i), base + i, e, 1);
        end
        check_eq("t3_rises", n_rise - r0, 0);

        // Test 4: three over, in range, three under, in range: never trips
        pulse_reset("t4_rst");
        base = ev_avg.size();
        r0   = n_rise;
        feed(8, 12'd4095);
        feed(8, 12'd0);
        feed(2, 12'd4095);
        idle(4);
        check_eq("t4_count", ev_avg.size() - base, 11);
        for (int i = 0; i < 11; i++) check_ev($sformatf("t4_ev%0d", i), base + i, exp4[i], rng4[i]);
        check_eq("t4_rises", n_rise - r0, 0);
        check_eq("t4_fault", int'(fault), 0);

        // Test 5: clear_fault in the cycle of the tripping classification
        pulse_reset("t5_rst");
        base = ev_avg.size();
        r0   = n_rise;
        feed(11, 12'd4095);
        tick(1'b0, 12'd0, 1'b0);
        tick(1'b0, 12'd0, 1'b1);
        idle(3);
        check_eq("t5_count", ev_avg.size() - base, 4);
        check_eq("t5_rises_a", n_rise - r0, 0);
        check_eq("t5_fault_a", int'(fault), 0);
        feed(3, 12'd4095);
        idle(4);
        check_eq("t5_fault_b", int'(fault), 0);
        feed(1, 12'd4095);
        idle(4);
        check_eq("t5_fault_c", int'(fault), 1);
        check_eq("t5_code_c", int'(fault_code), 1);
        check_eq("t5_rises_c", n_rise - r0, 1);

        // Test 6: reset mid-fill discards the partial window
        pulse_reset("t6_rst_a");
        base = ev_avg.size();
        feed(5, 12'd2048);
        idle(1);
        pulse_reset("t6_rst_b");
        feed(7, 12'd2048);
        idle(4);
        check_eq("t6_count_a", ev_avg.size() - base, 0);
        feed(1, 12'd2048);
        first = last_drv_cyc;
        idle(4);
        check_eq("t6_count_b", ev_avg.size() - base, 1);
        check_ev("t6_ev", base, 2048, 1);
        if (ev_cyc.size() > base) check_eq("t6_lat", ev_cyc[base], first + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
